// File: rtl/pla_exhaustive_driver_pkg.sv
// Shared types and constants for the PLA exhaustive sweep harness.
// Holds the FSM states, CRC defaults and the ones-count width helper.
package pla_harness_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_SEED = 16'hFFFF;

   // Bits needed to count 0..2^n ones.
   function automatic int cnt_w(input int n);
      return $clog2((1 << n) + 1);
   endfunction

endpackage

// File: rtl/pla_exhaustive_driver_if.sv
// Handshake and result bus between the sweep harness and its user.
// master = harness side, slave = controller / netlist side.
interface pla_exhaustive_driver_if #(
   parameter int N_IN  = 8,
   parameter int SIG_W = 16
);
   logic              start;
   logic              hold;
   logic              y_in;
   logic [N_IN-1:0]   x;
   logic              busy;
   logic              done;
   logic [N_IN:0]     ones_cnt;
   logic [SIG_W-1:0]  signature;

   modport master (
      input  start, hold, y_in,
      output x, busy, done, ones_cnt, signature
   );

   modport slave (
      output start, hold, y_in,
      input  x, busy, done, ones_cnt, signature
   );
endinterface

// File: rtl/pla_exhaustive_driver_sig.sv
// Response compactor: ones counter plus serial CRC signature.
// One instance per netlist output bit.
module pla_sig_compactor #(
   parameter int               CNT_W    = 9,
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] POLY     = 16'h1021,
   parameter logic [SIG_W-1:0] SIG_INIT = 16'hFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_sample_en,
   input  logic             i_sample_bit,
   output logic [CNT_W-1:0] o_ones_cnt,
   output logic [SIG_W-1:0] o_signature
);
   logic [CNT_W-1:0] r_cnt;
   logic [SIG_W-1:0] r_sig;
   logic             w_fb;

   assign w_fb = r_sig[SIG_W-1] ^ i_sample_bit;

   // Count ones and shift CRC on every valid sample; clear reloads the seed.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
         r_sig <= SIG_INIT;
      end else if (i_sample_en) begin
         r_cnt <= r_cnt + CNT_W'(i_sample_bit);
         r_sig <= (r_sig << 1) ^ (w_fb ? POLY : '0);
      end
   end

   assign o_ones_cnt  = r_cnt;
   assign o_signature = r_sig;
endmodule

// File: rtl/pla_exhaustive_driver.sv
// Exhaustive input sweep for a combinational PLA netlist.
// Issues every vector once, samples y after LAT cycles, compacts responses.
module pla_exhaustive_driver
   import pla_harness_pkg::*;
#(
   parameter int               N_IN     = 8,
   parameter int               LAT      = 0,
   parameter int               SIG_W    = 16,
   parameter logic [SIG_W-1:0] POLY     = SIG_W'(CRC_POLY),
   parameter logic [SIG_W-1:0] SIG_INIT = SIG_W'(CRC_SEED)
) (
   input logic                    clk,
   input logic                    rst,
   pla_exhaustive_driver_if.master bus
);
   localparam int            CW     = cnt_w(N_IN);
   localparam logic [N_IN:0] VC_END = (N_IN+1)'((1 << N_IN) - 1);
   localparam logic [N_IN:0] VC_ONE = (N_IN+1)'(1);
   localparam logic [N_IN-1:0] X_ONE = N_IN'(1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N_IN:0]   r_vc;
   logic [N_IN-1:0] r_x;
   logic            w_start_ok;
   logic            w_issue;
   logic            w_last;
   logic            w_tok;
   logic            w_dl_empty;
   logic [CW-1:0]   w_ones;
   logic [SIG_W-1:0] w_sig;

   assign w_start_ok = bus.start &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_issue    = (r_state == ST_RUN) && !bus.hold;
   assign w_last     = w_issue && (r_vc == VC_END);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; DRAIN waits for the delay line to empty.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_start_ok) w_state_nxt = ST_RUN;
         ST_DONE:  if (w_start_ok) w_state_nxt = ST_RUN;
         ST_RUN:   if (w_last)     w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_dl_empty) w_state_nxt = ST_DONE;
      endcase
   end

   // Vector counter; x shows the pending vector and freezes on the last one.
   always_ff @(posedge clk) begin
      if (rst || w_start_ok) begin
         r_vc <= '0;
         r_x  <= '0;
      end else if (w_issue) begin
         r_vc <= r_vc + VC_ONE;
         if (!w_last) r_x <= r_x + X_ONE;
      end
   end

   generate
      if (LAT == 0) begin : g_nodl
         assign w_tok      = w_issue;
         assign w_dl_empty = 1'b1;
      end else begin : g_dl
         logic [LAT-1:0] r_dl;
         // Issue tokens shift through LAT stages; bubbles when held.
         always_ff @(posedge clk) begin
            if (rst) r_dl <= '0;
            else     r_dl <= LAT'({r_dl, w_issue});
         end
         assign w_tok      = r_dl[LAT-1];
         assign w_dl_empty = ~|r_dl;
      end
   endgenerate

   pla_sig_compactor #(
      .CNT_W    (CW),
      .SIG_W    (SIG_W),
      .POLY     (POLY),
      .SIG_INIT (SIG_INIT)
   ) u_sig (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_start_ok),
      .i_sample_en  (w_tok),
      .i_sample_bit (bus.y_in),
      .o_ones_cnt   (w_ones),
      .o_signature  (w_sig)
   );

   assign bus.x         = r_x;
   assign bus.busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.ones_cnt  = (N_IN+1)'(w_ones);
   assign bus.signature = w_sig;
endmodule
